// File: rtl/sca_channel_enable_ctrl.sv
// sca_channel_enable_ctrl: owns the channel-enable vector for the SCA network.
// Replies are held after new enables until the gated resets have released.
module sca_channel_enable_ctrl #(
    parameter int N_CH   = 22,
    parameter int SETTLE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [7:0]      cmd_code,
    input  logic [7:0]      cmd_trid,
    input  logic [7:0]      cmd_data,
    output logic            rep_valid,
    input  logic            rep_ready,
    output logic [7:0]      rep_trid,
    output logic [7:0]      rep_err,
    output logic [7:0]      rep_data,
    output logic [N_CH-1:0] ch_enable,
    output logic            ch_busy
);

    localparam int CRD_W = N_CH - 16;
    localparam logic [3:0] CNT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    localparam logic [7:0] WR_CRB = 8'h02;
    localparam logic [7:0] RD_CRB = 8'h03;
    localparam logic [7:0] WR_CRC = 8'h04;
    localparam logic [7:0] RD_CRC = 8'h05;
    localparam logic [7:0] WR_CRD = 8'h06;
    localparam logic [7:0] RD_CRD = 8'h07;
    localparam logic [7:0] ERR_INVALID = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SETTLE,
        S_REPLY
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [7:0]        trid_q, trid_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]   en_q, en_d;
    logic [7:0]        rtrid_q, rtrid_d;
    logic [7:0]        rerr_q, rerr_d;
    logic [7:0]        rdata_q, rdata_d;

    logic [N_CH-1:0]   en_new;
    logic [7:0]        crd_new;
    logic [7:0]        rd_val;
    logic              cmd_ok;

    assign cmd_ready = (state_q == S_IDLE);
    assign rep_valid = (state_q == S_REPLY);
    assign ch_busy   = (state_q == S_SETTLE);
    assign rep_trid  = rtrid_q;
    assign rep_err   = rerr_q;
    assign rep_data  = rdata_q;
    assign ch_enable = en_q;

    // Next-state, command decode and register update
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        trid_d  = trid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rtrid_d = rtrid_q;
        rerr_d  = rerr_q;
        rdata_d = rdata_q;
        en_new  = en_q;
        crd_new = '0;
        rd_val  = '0;
        cmd_ok  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    code_d  = cmd_code;
                    trid_d  = cmd_trid;
                    data_d  = cmd_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (code_q)
                    WR_CRB: en_new[7:0]       = data_q;
                    WR_CRC: en_new[15:8]      = data_q;
                    WR_CRD: en_new[N_CH-1:16] = data_q[CRD_W-1:0];
                    RD_CRB, RD_CRC, RD_CRD: cmd_ok = 1'b1;
                    default: cmd_ok = 1'b0;
                endcase
                crd_new[CRD_W-1:0] = en_new[N_CH-1:16];
                case (code_q)
                    WR_CRB, RD_CRB: rd_val = en_new[7:0];
                    WR_CRC, RD_CRC: rd_val = en_new[15:8];
                    WR_CRD, RD_CRD: rd_val = crd_new;
                    default:        rd_val = 8'h00;
                endcase
                en_d    = en_new;
                rtrid_d = trid_q;
                rerr_d  = cmd_ok ? 8'h00 : ERR_INVALID;
                rdata_d = rd_val;
                cnt_d   = CNT_LOAD;
                if ((|(en_new & ~en_q)) && (SETTLE > 0)) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_REPLY;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_REPLY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REPLY: begin
                if (rep_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            trid_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            rtrid_q <= '0;
            rerr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            trid_q  <= trid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rtrid_q <= rtrid_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sca_channel_enable_ctrl.sv
// tb_sca_channel_enable_ctrl: scoreboard bench for the channel-enable
// responder; replies are predicted at issue time and popped on arrival.
module tb_sca_channel_enable_ctrl;

    localparam int N_CH = 22;
    localparam int SET  = 4;

    typedef struct {
        logic [7:0] trid;
        logic [7:0] err;
        logic [7:0] data;
    } rep_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [7:0]      cmd_code = '0;
    logic [7:0]      cmd_trid = '0;
    logic [7:0]      cmd_data = '0;
    logic            rep_valid;
    logic            rep_ready = 1'b1;
    logic [7:0]      rep_trid;
    logic [7:0]      rep_err;
    logic [7:0]      rep_data;
    logic [N_CH-1:0] ch_enable;
    logic            ch_busy;

    int n_cmp = 0;
    int n_err = 0;
    rep_t exp_q[$];
    logic [N_CH-1:0] en_m = '0;

    sca_channel_enable_ctrl #(.N_CH(N_CH), .SETTLE(SET)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_trid(cmd_trid), .cmd_data(cmd_data),
        .rep_valid(rep_valid), .rep_ready(rep_ready),
        .rep_trid(rep_trid), .rep_err(rep_err), .rep_data(rep_data),
        .ch_enable(ch_enable), .ch_busy(ch_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: predicts the reply and latency, updates the model vector.
    task automatic model(input logic [7:0] code, trid, data, output int lat);
        logic [N_CH-1:0] nx;
        rep_t r;
        nx = en_m;
        r.trid = trid;
        r.err = 8'h00;
        r.data = 8'h00;
        case (code)
            8'h02: nx[7:0] = data;
            8'h04: nx[15:8] = data;
            8'h06: nx[21:16] = data[5:0];
            8'h03, 8'h05, 8'h07: ;
            default: r.err = 8'h04;
        endcase
        case (code)
            8'h02, 8'h03: r.data = nx[7:0];
            8'h04, 8'h05: r.data = nx[15:8];
            8'h06, 8'h07: r.data = {2'b00, nx[21:16]};
            default: r.data = 8'h00;
        endcase
        lat = (|(nx & ~en_m)) ? 2 + SET : 2;
        en_m = nx;
        exp_q.push_back(r);
    endtask

    // Drive a command from a falling edge; returns one falling edge after accept.
    task automatic issue(input logic [7:0] code, trid, data, output bit to);
        int k;
        cmd_code = code;
        cmd_trid = trid;
        cmd_data = data;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        to = (k >= 50);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Observe a reply; lat counts falling edges since the accept edge.
    task automatic collect(output int lat, output int busy,
                           output logic [7:0] rt, re, rd,
                           output logic [N_CH-1:0] en1, en2,
                           output bit to);
        int n;
        n = 1;
        busy = 0;
        en1 = ch_enable;
        en2 = ch_enable;
        to = 1'b1;
        rt = '0;
        re = '0;
        rd = '0;
        while (n < 40) begin
            if (n == 2) en2 = ch_enable;
            if (ch_busy) busy++;
            if (rep_valid) begin
                to = 1'b0;
                rt = rep_trid;
                re = rep_err;
                rd = rep_data;
                break;
            end
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rep_valid, ch_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100",
                     {cmd_ready, rep_valid, ch_busy});
        end
        n_cmp++;
        if ({ch_enable, rep_trid, rep_err, rep_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got en=%h trid=%h err=%h data=%h want 0",
                     ch_enable, rep_trid, rep_err, rep_data);
        end
        reset = 1'b0;
        en_m = '0;
    endtask

    task automatic test_set_settle();
        int lat, elat, busy;
        logic [7:0] rt, re, rd;
        logic [N_CH-1:0] en1, en2, em;
        bit to, ito;
        rep_t r;
        model(8'h02, 8'h11, 8'h05, elat);
        em = en_m;
        issue(8'h02, 8'h11, 8'h05, ito);
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (en1 !== 22'h0 || en2 !== em) begin
            n_err++;
            $display("FAIL set_enable: got old=%h new=%h want old=0 new=%h", en1, en2, em);
        end
        n_cmp++;
        if (busy !== SET || lat !== elat || lat !== 6) begin
            n_err++;
            $display("FAIL set_timing: got busy=%0d lat=%0d want busy=%0d lat=6", busy, lat, SET);
        end
        n_cmp++;
        if (to || ito || rt !== r.trid || re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL set_reply: got to=%0d trid=%h err=%h data=%h want %h %h %h",
                     to | ito, rt, re, rd, r.trid, r.err, r.data);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_only();
        int lat, elat, busy;
        logic [7:0] rt, re, rd;
        logic [N_CH-1:0] en1, en2, em;
        bit to, ito;
        rep_t r;
        model(8'h02, 8'h12, 8'h01, elat);
        em = en_m;
        issue(8'h02, 8'h12, 8'h01, ito);
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (en2 !== em || busy !== 0 || lat !== 2 || lat !== elat) begin
            n_err++;
            $display("FAIL clear_only: got en=%h busy=%0d lat=%0d want en=%h busy=0 lat=2",
                     en2, busy, lat, em);
        end
        n_cmp++;
        if (to || ito || rt !== r.trid || re !== r.err || rd !== 8'h01 || rd !== r.data) begin
            n_err++;
            $display("FAIL clear_reply: got trid=%h err=%h data=%h want %h %h 01",
                     rt, re, rd, r.trid, r.err);
        end
        @(negedge clk);
    endtask

    task automatic test_crd();
        int lat, elat, busy;
        logic [7:0] rt, re, rd;
        logic [N_CH-1:0] en1, en2, em;
        bit to, ito;
        rep_t r;
        model(8'h06, 8'h21, 8'hFF, elat);
        em = en_m;
        issue(8'h06, 8'h21, 8'hFF, ito);
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (en2 !== em || en2[21:16] !== 6'h3F || lat !== elat || busy !== SET) begin
            n_err++;
            $display("FAIL crd_write: got en=%h lat=%0d busy=%0d want en=%h lat=%0d busy=%0d",
                     en2, lat, busy, em, elat, SET);
        end
        n_cmp++;
        if (to || ito || rt !== r.trid || re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL crd_wr_reply: got trid=%h err=%h data=%h want %h %h %h",
                     rt, re, rd, r.trid, r.err, r.data);
        end
        @(negedge clk);
        model(8'h07, 8'h22, 8'h00, elat);
        issue(8'h07, 8'h22, 8'h00, ito);
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (to || ito || lat !== elat || rt !== r.trid || re !== 8'h00 ||
            rd !== 8'h3F || rd !== r.data) begin
            n_err++;
            $display("FAIL crd_read: got lat=%0d trid=%h err=%h data=%h want 2 %h 00 3f",
                     lat, rt, re, rd, r.trid);
        end
        @(negedge clk);
    endtask

    task automatic test_invalid();
        int lat, elat, busy;
        logic [7:0] rt, re, rd;
        logic [N_CH-1:0] en1, en2, em;
        bit to, ito;
        rep_t r;
        em = en_m;
        model(8'h99, 8'h7E, 8'hAA, elat);
        issue(8'h99, 8'h7E, 8'hAA, ito);
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (en2 !== em || busy !== 0 || lat !== 2) begin
            n_err++;
            $display("FAIL invalid_state: got en=%h busy=%0d lat=%0d want en=%h busy=0 lat=2",
                     en2, busy, lat, em);
        end
        n_cmp++;
        if (to || ito || rt !== 8'h7E || re !== 8'h04 || rd !== 8'h00 ||
            re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL invalid_reply: got trid=%h err=%h data=%h want 7e 04 00", rt, re, rd);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, elat, busy, gap;
        logic [7:0] rt, re, rd, at, ae, ad;
        logic [N_CH-1:0] en1, en2;
        bit to, ito, got;
        rep_t r;
        rep_ready = 1'b1;
        model(8'h03, 8'h31, 8'h00, elat);
        issue(8'h03, 8'h31, 8'h00, ito);
        model(8'h05, 8'h32, 8'h00, elat);
        cmd_code = 8'h05;
        cmd_trid = 8'h32;
        cmd_data = 8'h00;
        cmd_valid = 1'b1;
        gap = 1;
        got = 1'b0;
        at = '0;
        ae = '0;
        ad = '0;
        while (!cmd_ready && gap < 20) begin
            if (rep_valid && !got) begin
                got = 1'b1;
                at = rep_trid;
                ae = rep_err;
                ad = rep_data;
            end
            @(negedge clk);
            gap++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        collect(lat, busy, rt, re, rd, en1, en2, to);
        n_cmp++;
        if (gap !== 3) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d cycles between accepts want 3", gap);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if (ito || !got || at !== r.trid || ae !== r.err || ad !== r.data) begin
            n_err++;
            $display("FAIL b2b_first: got seen=%0d trid=%h err=%h data=%h want %h %h %h",
                     got, at, ae, ad, r.trid, r.err, r.data);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== elat || rt !== r.trid || re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d trid=%h err=%h data=%h want %0d %h %h %h",
                     lat, rt, re, rd, elat, r.trid, r.err, r.data);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat, elat, busy;
        logic [7:0] rt, re, rd;
        logic [N_CH-1:0] en1, en2;
        bit to, ito, stable, rdy_idle, rdy_exec;
        rep_t r;
        rep_ready = 1'b0;
        model(8'h05, 8'h41, 8'h00, elat);
        issue(8'h05, 8'h41, 8'h00, ito);
        model(8'h03, 8'h42, 8'h00, elat);
        cmd_code = 8'h03;
        cmd_trid = 8'h42;
        cmd_valid = 1'b1;
        collect(lat, busy, rt, re, rd, en1, en2, to);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rep_valid || cmd_ready || rep_trid !== rt ||
                rep_err !== re || rep_data !== rd) stable = 1'b0;
        end
        rep_ready = 1'b1;
        @(negedge clk);
        rdy_idle = cmd_ready;
        @(negedge clk);
        rdy_exec = cmd_ready;
        cmd_valid = 1'b0;
        n_cmp++;
        if (to || !stable) begin
            n_err++;
            $display("FAIL bp_hold: got timeout=%0d stable=%0d want 0 1", to, stable);
        end
        n_cmp++;
        if (rdy_idle !== 1'b1 || rdy_exec !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got ready idle/next=%b%b want 10", rdy_idle, rdy_exec);
        end
        r = exp_q.pop_front();
        n_cmp++;
        if (ito || rt !== r.trid || re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL bp_first: got trid=%h err=%h data=%h want %h %h %h",
                     rt, re, rd, r.trid, r.err, r.data);
        end
        collect(lat, busy, rt, re, rd, en1, en2, to);
        r = exp_q.pop_front();
        n_cmp++;
        if (to || lat !== elat || rt !== r.trid || re !== r.err || rd !== r.data) begin
            n_err++;
            $display("FAIL bp_second: got lat=%0d trid=%h err=%h data=%h want %0d %h %h %h",
                     lat, rt, re, rd, elat, r.trid, r.err, r.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_settle();
        logic [N_CH-1:0] em, en_set;
        bit ito, busy1;
        int seen;
        em = en_m;
        em[15:8] = 8'hF0;
        issue(8'h04, 8'h51, 8'hF0, ito);
        @(negedge clk);
        en_set = ch_enable;
        busy1 = ch_busy;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ito || en_set !== em || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_settle_pre: got en=%h busy=%0d want en=%h busy=1", en_set, busy1, em);
        end
        n_cmp++;
        if (ch_enable !== '0 || rep_valid !== 1'b0 || ch_busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_settle_rst: got en=%h vld=%b busy=%b rdy=%b want 0 0 0 1",
                     ch_enable, rep_valid, ch_busy, cmd_ready);
        end
        reset = 1'b0;
        en_m = '0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rep_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || ch_enable !== '0) begin
            n_err++;
            $display("FAIL mid_settle_noreply: got %0d reply cycles en=%h want 0 0", seen, ch_enable);
        end
    endtask

    initial begin
        test_reset();
        test_set_settle();
        test_clear_only();
        test_crd();
        test_invalid();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_settle();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
